dreq_fifo_source: RTL and testbench

- External-peripheral model: the far end of the DMAC's DREQ/DACK handshake and a DBUS responder.
- Buffers words from a producer port in a FIFO and asserts DREQ while data is available.
- Answers DMA reads (DACK active) with wait states, popping one word per completed read.
- Used as the device side in DMAC single-address and dual-address transfer benches and in system integration.

---
 rtl/dreq_fifo_source.sv | 183 ++++++++++++++++++
 tb/tb_dreq_fifo_source.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dreq_fifo_source.sv
// Peripheral-side model for a DMAC: a producer-fed word FIFO that drives DREQ and
// answers DACK-qualified bus reads with programmable wait states.
module dreq_fifo_source #(
    parameter int          DEPTH       = 16,
    parameter int          THRESH      = 1,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        DL,
    input  logic        DS,
    input  logic        AL,
    output logic        DREQ,
    input  logic        DACK,
    input  logic [31:0] BUS_A,
    input  logic [31:0] BUS_DI,
    output logic [31:0] BUS_DO,
    input  logic        BUS_WE,
    input  logic        BUS_REQ,
    output logic        BUS_WAIT,
    input  logic        PUSH,
    input  logic [31:0] PUSH_DATA,
    output logic        FULL,
    input  logic        CLR,
    output logic        OVERRUN,
    output logic        UNDERRUN
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [3:0]    WAIT_C   = 4'(WAIT_STATES);

    typedef enum logic [2:0] {IDLE, DREAD, SREAD, WDONE, DONE} state_t;

    state_t        state_reg;
    logic [3:0]    wait_reg;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [31:0]   bus_do_reg;
    logic [31:0]   last_data_reg;
    logic          bus_wait_reg;
    logic          full_reg;
    logic          overrun_reg;
    logic          underrun_reg;
    logic          dreq_reg;

    logic          sel;
    logic          acked;
    logic          push_ok;
    logic          read_done;
    logic          pop;
    logic          underflow;
    logic          req_raw;
    logic [7:0]    count_lo;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign sel         = BUS_REQ & (BUS_A[31:2] == BASE_ADDR[31:2]);
    assign acked       = (DACK == AL);
    // The access completes on the CE_R cycle that brings the wait counter to zero.
    assign read_done   = ((state_reg == DREAD) || (state_reg == SREAD)) && (wait_reg <= 4'd1);
    assign pop         = read_done && (state_reg == DREAD) && (count_reg != '0);
    assign underflow   = read_done && (state_reg == DREAD) && (count_reg == '0);
    assign push_ok     = PUSH && (count_reg != DEPTH_C);
    assign req_raw     = (count_next >= THRESH_C);
    assign count_lo    = 8'(count_reg);
    assign status_word = {overrun_reg, underrun_reg, 22'b0, count_lo};
    assign unused_bits = ^{BUS_DI, BUS_A[1:0]};

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (CE_R && push_ok) begin
            mem[wr_ptr_reg] <= PUSH_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg     <= IDLE;
            wait_reg      <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            bus_do_reg    <= '0;
            last_data_reg <= '0;
            bus_wait_reg  <= 1'b0;
            full_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            underrun_reg  <= 1'b0;
            dreq_reg      <= ~DL;
        end else if (CE_R) begin
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_C);
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end

            // Edge mode forces one inactive cycle per pop so each transfer yields a fresh edge.
            if (DS && pop) begin
                dreq_reg <= ~DL;
            end else begin
                dreq_reg <= req_raw ? DL : ~DL;
            end

            if (PUSH && !push_ok) begin
                overrun_reg <= 1'b1;
            end else if (CLR) begin
                overrun_reg <= 1'b0;
            end
            if (underflow) begin
                underrun_reg <= 1'b1;
            end else if (CLR) begin
                underrun_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (sel) begin
                        if (BUS_WE) begin
                            state_reg    <= WDONE;
                            bus_wait_reg <= 1'b0;
                        end else begin
                            state_reg    <= acked ? DREAD : SREAD;
                            wait_reg     <= WAIT_C;
                            bus_wait_reg <= (WAIT_C != 4'd0);
                        end
                    end
                end
                DREAD, SREAD: begin
                    if (read_done) begin
                        bus_wait_reg <= 1'b0;
                        wait_reg     <= '0;
                        state_reg    <= DONE;
                        if (state_reg == SREAD) begin
                            bus_do_reg <= status_word;
                        end else if (count_reg != '0) begin
                            bus_do_reg    <= mem[rd_ptr_reg];
                            last_data_reg <= mem[rd_ptr_reg];
                        end else begin
                            bus_do_reg <= last_data_reg;
                        end
                    end else begin
                        wait_reg <= wait_reg - 4'd1;
                    end
                end
                WDONE, DONE: begin
                    bus_wait_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg    <= IDLE;
                    bus_wait_reg <= 1'b0;
                end
            endcase
        end
    end

    assign DREQ     = dreq_reg;
    assign BUS_DO   = bus_do_reg;
    assign BUS_WAIT = bus_wait_reg;
    assign FULL     = full_reg;
    assign OVERRUN  = overrun_reg;
    assign UNDERRUN = underrun_reg;
endmodule

// File: tb/tb_dreq_fifo_source.sv
// Bench for dreq_fifo_source: a cycle-vector table for DREQ/CE_R/reset behaviour plus
// hand-written bus sequences checked against a FIFO scoreboard.
module tb_dreq_fifo_source;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        CLK = 1'b0;
    logic        RST_N, CE_R, DL, DS, AL, DACK;
    logic [31:0] BUS_A, BUS_DI, PUSH_DATA;
    logic        BUS_WE, BUS_REQ, PUSH, CLR;
    logic        DREQ, BUS_WAIT, FULL, OVERRUN, UNDERRUN;
    logic [31:0] BUS_DO;

    dreq_fifo_source #(
        .DEPTH(16), .THRESH(1), .WAIT_STATES(2), .BASE_ADDR(BASE)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .DL(DL), .DS(DS), .AL(AL),
        .DREQ(DREQ), .DACK(DACK), .BUS_A(BUS_A), .BUS_DI(BUS_DI), .BUS_DO(BUS_DO),
        .BUS_WE(BUS_WE), .BUS_REQ(BUS_REQ), .BUS_WAIT(BUS_WAIT), .PUSH(PUSH),
        .PUSH_DATA(PUSH_DATA), .FULL(FULL), .CLR(CLR), .OVERRUN(OVERRUN),
        .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n;
        logic        ce;
        logic        dl;
        logic        push;
        logic [31:0] data;
        logic        exp_dreq;
        logic        exp_full;
    } vec_t;

    vec_t        tbl[9];
    logic [31:0] sb[$];
    logic [31:0] last_model;
    logic        exp_ovr, exp_und;
    logic [31:0] rd_data;
    logic        dreq_done, dreq_after;
    logic [31:0] saved;
    int          checks = 0;
    int          failures = 0;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        last_model = '0;
        exp_ovr    = 1'b0;
        exp_und    = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic push_word(input logic [31:0] d);
        PUSH = 1'b1;
        PUSH_DATA = d;
        if (sb.size() < 16) sb.push_back(d);
        else exp_ovr = 1'b1;
        cyc();
        PUSH = 1'b0;
        $display("push %h depth=%0d", d, sb.size());
    endtask

    // One bus read; optionally pushes a word so it lands on the completion edge.
    task automatic bus_read(input logic dack_on, input logic push_mid, input logic [31:0] pd);
        int n = 0;
        BUS_REQ = 1'b1;
        BUS_A   = BASE;
        BUS_WE  = 1'b0;
        DACK    = dack_on ? AL : ~AL;
        cyc();
        while (BUS_WAIT && n < 20) begin
            n++;
            if (push_mid && n == 2) begin
                PUSH = 1'b1;
                PUSH_DATA = pd;
                sb.push_back(pd);
            end
            cyc();
        end
        PUSH = 1'b0;
        check("wait_states", 32'(n), 32'd2);
        rd_data   = BUS_DO;
        dreq_done = DREQ;
        BUS_REQ   = 1'b0;
        DACK      = ~AL;
        cyc();
        dreq_after = DREQ;
    endtask

    task automatic dack_read(input logic push_mid, input logic [31:0] pd);
        logic [31:0] exp;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            last_model = exp;
        end else begin
            exp = last_model;
            exp_und = 1'b1;
        end
        bus_read(1'b1, push_mid, pd);
        check("dack_data", rd_data, exp);
        $display("dack read %h expect %h depth=%0d", rd_data, exp, sb.size());
    endtask

    task automatic status_read();
        logic [31:0] exp;
        exp = {exp_ovr, exp_und, 22'b0, 8'(sb.size())};
        bus_read(1'b0, 1'b0, '0);
        check("status", rd_data, exp);
        $display("status read %h expect %h", rd_data, exp);
    endtask

    initial begin
        RST_N = 1'b0; CE_R = 1'b1; DL = 1'b0; DS = 1'b0; AL = 1'b1; DACK = 1'b0;
        BUS_A = '0; BUS_DI = '0; BUS_WE = 1'b0; BUS_REQ = 1'b0;
        PUSH = 1'b0; PUSH_DATA = '0; CLR = 1'b0;
        model_reset();

        // rst_n, ce, dl, push, data, exp_dreq, exp_full
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD0001, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            RST_N = tbl[i].rst_n; CE_R = tbl[i].ce; DL = tbl[i].dl;
            PUSH = tbl[i].push; PUSH_DATA = tbl[i].data;
            cyc();
            check($sformatf("vec%0d_dreq", i), 32'(DREQ), 32'(tbl[i].exp_dreq));
            check($sformatf("vec%0d_full", i), 32'(FULL), 32'(tbl[i].exp_full));
            $display("vec %0d dreq=%b full=%b", i, DREQ, FULL);
        end
        PUSH = 1'b0; CE_R = 1'b1; RST_N = 1'b1;

        // Level-mode burst, DREQ active low
        DL = 1'b0;
        do_reset();
        check("reset_dreq", 32'(DREQ), 32'd1);
        check("reset_wait", 32'(BUS_WAIT), 32'd0);
        check("reset_do", BUS_DO, 32'h0);
        push_word(32'h11111111);
        check("lvl_dreq_on", 32'(DREQ), 32'd0);
        push_word(32'h22222222);
        push_word(32'h33333333);
        dack_read(1'b0, '0);
        check("lvl_dreq_r1", 32'(dreq_done), 32'd0);
        dack_read(1'b0, '0);
        check("lvl_dreq_r2", 32'(dreq_done), 32'd0);
        dack_read(1'b0, '0);
        check("lvl_dreq_r3", 32'(dreq_done), 32'd1);
        status_read();

        // Edge mode, DREQ active high
        DS = 1'b1; DL = 1'b1;
        cyc();
        check("edge_idle_dreq", 32'(DREQ), 32'd0);
        for (int i = 0; i < 4; i++) push_word(32'hE0000000 + 32'(i));
        check("edge_dreq_on", 32'(DREQ), 32'd1);
        for (int i = 0; i < 4; i++) begin
            dack_read(1'b0, '0);
            check($sformatf("edge_drop%0d", i), 32'(dreq_done), 32'd0);
            check($sformatf("edge_back%0d", i), 32'(dreq_after), (i < 3) ? 32'd1 : 32'd0);
        end
        DS = 1'b0; DL = 1'b0;
        cyc();
        check("lvl_return", 32'(DREQ), 32'd1);

        // Full / overrun with pointer wrap
        for (int i = 0; i < 17; i++) begin
            push_word(32'(i));
            if (i == 14) check("full_at_15", 32'(FULL), 32'd0);
            if (i == 15) begin
                check("full_at_16", 32'(FULL), 32'd1);
                check("no_ovr_yet", 32'(OVERRUN), 32'd0);
            end
        end
        check("overrun_set", 32'(OVERRUN), 32'd1);
        check("full_held", 32'(FULL), 32'd1);
        for (int i = 0; i < 16; i++) begin
            dack_read(1'b0, '0);
            if (i == 0) check("full_cleared", 32'(FULL), 32'd0);
        end
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        exp_ovr = 1'b0;
        check("overrun_clr", 32'(OVERRUN), 32'd0);

        // Underrun repeats the last popped word
        push_word(32'hCAFEF00D);
        dack_read(1'b0, '0);
        check("no_und_yet", 32'(UNDERRUN), 32'd0);
        dack_read(1'b0, '0);
        check("underrun_set", 32'(UNDERRUN), 32'd1);
        status_read();
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        exp_und = 1'b0;
        check("underrun_clr", 32'(UNDERRUN), 32'd0);

        // Status read and discarded write
        for (int i = 0; i < 5; i++) push_word(32'h50000000 + 32'(i));
        status_read();
        saved = rd_data;
        BUS_REQ = 1'b1; BUS_A = BASE; BUS_WE = 1'b1; BUS_DI = 32'hFFFFFFFF;
        cyc();
        check("write_nowait", 32'(BUS_WAIT), 32'd0);
        BUS_REQ = 1'b0; BUS_WE = 1'b0;
        cyc();
        check("write_do_hold", BUS_DO, 32'h00000005);
        $display("write done bus_do=%h (was %h)", BUS_DO, saved);
        status_read();

        // Push on the completing DREAD edge at count 3
        dack_read(1'b0, '0);
        dack_read(1'b0, '0);
        dack_read(1'b1, 32'h77777777);
        status_read();
        for (int i = 0; i < 3; i++) dack_read(1'b0, '0);

        // Reset in the middle of a DACK read
        push_word(32'h5A5A5A5A);
        BUS_REQ = 1'b1; BUS_A = BASE; BUS_WE = 1'b0; DACK = AL;
        cyc();
        check("mid_wait", 32'(BUS_WAIT), 32'd1);
        RST_N = 1'b0; BUS_REQ = 1'b0; DACK = ~AL;
        cyc();
        RST_N = 1'b1;
        model_reset();
        check("rst_wait", 32'(BUS_WAIT), 32'd0);
        check("rst_dreq", 32'(DREQ), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        status_read();
        push_word(32'h600DCAFE);
        dack_read(1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
